// File: rtl/dbg_pkg.sv
// Shared definitions for the debug register-dump streamer: state encoding,
// register count and the default frame header byte.
`timescale 1ns/1ps
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } dump_state_e;

  localparam int         NUM_REGS          = 32;
  localparam logic [4:0] LAST_REG          = 5'(NUM_REGS - 1);
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/reg_dump_streamer.sv
// Freezes the core, walks x0..x31 through a register-file read port and
// streams every word MSB-first as bytes over a valid/ready interface.
`timescale 1ns/1ps
module reg_dump_streamer
  import dbg_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter bit         HEADER_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        dump_start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        cpu_enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  dump_state_e state_q, state_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        hs;

  assign hs = tx_valid_q & tx_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= 5'd0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_enable_q <= 1'b1;
      shift_q      <= 32'd0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_enable_q <= cpu_enable_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_enable_d = cpu_enable_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          busy_d       = 1'b1;
          cpu_enable_d = 1'b0;
          rd_addr_d    = 5'd0;
          if (HEADER_EN) begin
            state_d    = ST_HDR;
            tx_valid_d = 1'b1;
            tx_data_d  = SYNC_BYTE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_HDR: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end

      // rd_addr has been stable for a full cycle here, so rd_data is settled.
      ST_LOAD: begin
        shift_d    = rd_data;
        tx_data_d  = rd_data[31:24];
        tx_valid_d = 1'b1;
        cnt_d      = 2'd0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (hs) begin
          // Rotate instead of zero-fill; the wrapped byte is never transmitted.
          shift_d = {shift_q[23:0], shift_q[31:24]};
          cnt_d   = 2'(cnt_q + 2'd1);
          if (cnt_q != 2'd3) begin
            tx_data_d = shift_q[23:16];
          end else begin
            tx_valid_d = 1'b0;
            if (rd_addr_q == LAST_REG) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = 5'(rd_addr_q + 5'd1);
              state_d   = ST_LOAD;
            end
          end
        end
      end

      ST_DONE: begin
        done_d       = 1'b0;
        busy_d       = 1'b0;
        cpu_enable_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr    = rd_addr_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_enable = cpu_enable_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench: header and headerless streamers share one register-file model.
`timescale 1ns/1ps
module tb_reg_dump_streamer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;

  logic        dump_start_a = 1'b0, tx_ready_a = 1'b0;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic        cpu_enable_a, tx_valid_a, busy_a, done_a;
  logic [7:0]  tx_data_a;

  logic        dump_start_b = 1'b0, tx_ready_b = 1'b0;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        cpu_enable_b, tx_valid_b, busy_b, done_b;
  logic [7:0]  tx_data_b;

  logic [31:0] regs [32];
  logic        core_run = 1'b0, core_clr = 1'b0;
  logic [31:0] core_x5;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int busy_cyc, done_cnt, done_at, stall_bad, drop_bad, en_bad;
  bit timed_out;

  always #5 Clk = ~Clk;

  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

  // Stand-in core repeatedly executing addi x5,x5,1, write-gated by cpu_enable.
  always @(posedge Clk) begin
    if (core_clr)                       core_x5 <= 32'd100;
    else if (core_run && cpu_enable_a)  core_x5 <= core_x5 + 32'd1;
  end

  reg_dump_streamer #(.SYNC_BYTE(8'hA5), .HEADER_EN(1'b1)) dut_a (
    .Clk(Clk), .Rst(Rst), .dump_start(dump_start_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .cpu_enable(cpu_enable_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_streamer #(.SYNC_BYTE(8'hA5), .HEADER_EN(1'b0)) dut_b (
    .Clk(Clk), .Rst(Rst), .dump_start(dump_start_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .cpu_enable(cpu_enable_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b), .done(done_b)
  );

  task automatic build_exp(input bit hdr);
    logic [31:0] w;
    exp_q.delete();
    if (hdr) exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      w = (r == 0) ? 32'd0 : regs[r];
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) return i;
      if (got_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  // Caller raises dump_start just before calling; edge 0 of this loop samples it.
  task automatic collect(input bit inst_b, input int ready_low_pct, input int restart_at);
    logic v, r, bz, dn, en, prev_stall;
    logic [7:0] d, prev_d;
    int idle;
    bit seen;
    got_q.delete();
    busy_cyc = 0; done_cnt = 0; done_at = -1;
    stall_bad = 0; drop_bad = 0; en_bad = 0; timed_out = 1'b1;
    prev_stall = 1'b0; prev_d = 8'd0; idle = 0; seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge Clk); #1;
      if (k == 0 || k == restart_at + 1) begin
        dump_start_a = 1'b0; dump_start_b = 1'b0;
      end
      if (k == restart_at) begin
        if (inst_b) dump_start_b = 1'b1; else dump_start_a = 1'b1;
      end
      r = ($urandom_range(99) >= ready_low_pct);
      if (inst_b) tx_ready_b = r; else tx_ready_a = r;
      @(negedge Clk);
      v  = inst_b ? tx_valid_b   : tx_valid_a;
      d  = inst_b ? tx_data_b    : tx_data_a;
      bz = inst_b ? busy_b       : busy_a;
      dn = inst_b ? done_b       : done_a;
      en = inst_b ? cpu_enable_b : cpu_enable_a;
      if (prev_stall && !v) drop_bad++;
      if (prev_stall && v && d !== prev_d) stall_bad++;
      if (v && r) got_q.push_back(d);
      prev_stall = v && !r;
      prev_d = d;
      if (en === bz) en_bad++;
      if (dn) begin
        done_cnt++;
        done_at = k;
      end
      if (bz) begin
        busy_cyc++; seen = 1'b1; idle = 0;
      end else if (seen) begin
        idle++;
        if (idle >= 20) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (rd_addr_a !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr_a); end
    total++; if (tx_data_a !== 8'd0) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data_a); end
    total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_a); end
    total++; if (cpu_enable_a !== 1'b1) begin bad++; $display("FAIL reset_cpu_enable got=%b want=1", cpu_enable_a); end
    total++; if (tx_valid_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_b got valid=%b busy=%b want 0/0", tx_valid_b, busy_b); end
    @(posedge Clk); #1;
    Rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_clean_dump();
    int fd;
    build_exp(1'b1);
    @(posedge Clk); #1;
    dump_start_a = 1'b1;
    collect(1'b0, 0, -1);
    fd = first_diff();
    total++; if (timed_out) begin bad++; $display("FAIL clean_timeout got=timeout want=idle"); end
    total++; if (got_q.size() != 129) begin bad++; $display("FAIL clean_count got=%0d want=129", got_q.size()); end
    total++; if (fd != -1) begin bad++; $display("FAIL clean_bytes first diff at index %0d want none", fd); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL clean_done_count got=%0d want=1", done_cnt); end
    total++; if (done_at != 161) begin bad++; $display("FAIL clean_done_cycle got=%0d want=161", done_at); end
    total++; if (busy_cyc != 162) begin bad++; $display("FAIL clean_busy_cycles got=%0d want=162", busy_cyc); end
    total++; if (en_bad != 0) begin bad++; $display("FAIL clean_cpu_enable got=%0d cycles where cpu_enable==busy want=0", en_bad); end
    $display("clean dump: %0d bytes, done at cycle %0d, busy %0d cycles", got_q.size(), done_at, busy_cyc);
  endtask

  task automatic test_backpressure();
    int fd;
    build_exp(1'b1);
    @(posedge Clk); #1;
    dump_start_a = 1'b1;
    collect(1'b0, 30, -1);
    fd = first_diff();
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=timeout want=idle"); end
    total++; if (got_q.size() != 129) begin bad++; $display("FAIL bp_count got=%0d want=129", got_q.size()); end
    total++; if (fd != -1) begin bad++; $display("FAIL bp_bytes first diff at index %0d want none", fd); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_data_stable got=%0d unstable stalls want=0", stall_bad); end
    total++; if (drop_bad != 0) begin bad++; $display("FAIL bp_valid_drop got=%0d drops want=0", drop_bad); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
    $display("backpressure: %0d bytes over %0d busy cycles", got_q.size(), busy_cyc);
  endtask

  task automatic test_core_freeze();
    logic [31:0] x5_before;
    core_clr = 1'b1;
    @(posedge Clk); #1;
    core_clr = 1'b0;
    core_run = 1'b1;
    tx_ready_a = 1'b1;
    repeat (7) @(posedge Clk);
    #1;
    total++; if (core_x5 !== 32'd107) begin bad++; $display("FAIL freeze_core_runs got=%0d want=107", core_x5); end
    dump_start_a = 1'b1;
    @(posedge Clk); #1;
    dump_start_a = 1'b0;
    x5_before = core_x5;
    repeat (161) @(posedge Clk);
    #1;
    total++; if (cpu_enable_a !== 1'b0) begin bad++; $display("FAIL freeze_enable_161 got=%b want=0", cpu_enable_a); end
    @(posedge Clk); #1;
    total++; if (cpu_enable_a !== 1'b1) begin bad++; $display("FAIL freeze_enable_162 got=%b want=1", cpu_enable_a); end
    total++; if (core_x5 !== x5_before) begin bad++; $display("FAIL freeze_x5_held got=%0d want=%0d", core_x5, x5_before); end
    @(posedge Clk); #1;
    total++; if (core_x5 !== x5_before + 32'd1) begin bad++; $display("FAIL freeze_x5_resume got=%0d want=%0d", core_x5, x5_before + 32'd1); end
    core_run = 1'b0;
    $display("core freeze: x5 held at %0d during dump", x5_before);
  endtask

  task automatic test_reset_mid_dump();
    int hs, fd;
    bit found;
    regs[7] = 32'hCAFEF00D;
    tx_ready_a = 1'b1;
    hs = 0; found = 1'b0;
    @(posedge Clk); #1;
    dump_start_a = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(posedge Clk); #1;
      dump_start_a = 1'b0;
      @(negedge Clk);
      if (tx_valid_a && tx_ready_a) begin
        if (hs == 31) begin
          found = 1'b1;
          break;
        end
        hs++;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_byte got=%0d bytes want=31", hs); end
    total++; if (tx_data_a !== 8'hF0) begin bad++; $display("FAIL rst_byte2_x7 got=%h want=f0", tx_data_a); end
    Rst = 1'b1;
    @(posedge Clk); #1;
    total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
    total++; if (cpu_enable_a !== 1'b1) begin bad++; $display("FAIL rst_cpu_enable got=%b want=1", cpu_enable_a); end
    total++; if (rd_addr_a !== 5'd0) begin bad++; $display("FAIL rst_rd_addr got=%0d want=0", rd_addr_a); end
    Rst = 1'b0;
    build_exp(1'b1);
    @(posedge Clk); #1;
    dump_start_a = 1'b1;
    collect(1'b0, 0, -1);
    fd = first_diff();
    total++; if (got_q.size() == 0 || got_q[0] !== 8'hA5) begin bad++; $display("FAIL rst_restart_header got=%h want=a5", (got_q.size() == 0) ? 8'h00 : got_q[0]); end
    total++; if (fd != -1) begin bad++; $display("FAIL rst_restart_bytes first diff at index %0d want none", fd); end
    $display("reset mid-dump: aborted at byte %0d, restart produced %0d bytes", hs, got_q.size());
  endtask

  task automatic test_no_header_ignored_start();
    int fd;
    build_exp(1'b0);
    @(posedge Clk); #1;
    dump_start_b = 1'b1;
    collect(1'b1, 0, 50);
    fd = first_diff();
    total++; if (timed_out) begin bad++; $display("FAIL nohdr_timeout got=timeout want=idle"); end
    total++; if (got_q.size() != 128) begin bad++; $display("FAIL nohdr_count got=%0d want=128", got_q.size()); end
    total++; if (fd != -1) begin bad++; $display("FAIL nohdr_bytes first diff at index %0d want none", fd); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nohdr_done_count got=%0d want=1", done_cnt); end
    total++; if (done_at != 160) begin bad++; $display("FAIL nohdr_done_cycle got=%0d want=160", done_at); end
    total++; if (busy_cyc != 161) begin bad++; $display("FAIL nohdr_busy_cycles got=%0d want=161", busy_cyc); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL nohdr_other_idle got=%b want=0", busy_a); end
    $display("no header: %0d bytes, %0d done pulses", got_q.size(), done_cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1]  = 32'h12345678;
    regs[31] = 32'hDEADBEEF;
    test_reset();
    test_clean_dump();
    test_backpressure();
    test_core_freeze();
    test_reset_mid_dump();
    regs[9] = 32'h0BADF00D;
    test_no_header_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
